// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding and
// fetch constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus between the fetch sequencer (master) and the external instruction
// memory (slave). rdata is combinational from addr.
interface imem_fetch_ctrl_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/imem_fetch_ctrl_pc_reg.sv
// Program counter with load (highest priority), increment and hold.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: streams a program into instruction memory,
// then owns the PC and the IF/ID register (stall, redirect/flush, halt).
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 128,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_we,
    input  logic [31:0]               load_data,
    input  logic                      load_done,
    input  logic                      halt_req,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    imem_fetch_ctrl_if.master         imem,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_ir,
    output logic                      if_valid,
    output logic                      running,
    output logic                      halted,
    output logic                      err
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   load_ptr_q, load_ptr_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_ir_q, if_ir_d;
    logic               if_valid_q, if_valid_d;
    logic               err_q, err_d;

    logic               pc_load;
    logic [31:0]        pc_load_val;
    logic               pc_inc;
    logic [31:0]        pc;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        if_pc_d     = if_pc_q;
        if_ir_d     = if_ir_q;
        if_valid_d  = if_valid_q;
        err_d       = err_q;
        pc_load     = 1'b0;
        pc_load_val = RESET_PC;
        pc_inc      = 1'b0;
        imem.addr   = pc;
        imem.we     = 1'b0;
        imem.wdata  = load_data;

        unique case (state_q)
            ST_LOAD: begin
                imem.addr = 32'(load_ptr_q) << 2;
                if (load_we) begin
                    // A full memory drops the write and flags it; the pointer never wraps.
                    if (load_ptr_q == PTR_W'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        imem.we    = 1'b1;
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                end
                if (load_done) begin
                    state_d = ST_RUN;
                    pc_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d    = ST_HALT;
                    if_valid_d = 1'b0;
                end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                    err_d      = 1'b1;
                    state_d    = ST_HALT;
                    if_valid_d = 1'b0;
                end else if (redirect) begin
                    // Flush wins over stall: the wrong-path word must never reach ID.
                    pc_load     = 1'b1;
                    pc_load_val = redirect_pc;
                    if_valid_d  = 1'b0;
                    if_ir_d     = NOP;
                end else if (pc[31:2] >= 30'(DEPTH)) begin
                    state_d    = ST_HALT;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_ir_d    = imem.rdata;
                    if_pc_d    = pc;
                    if_valid_d = 1'b1;
                    pc_inc     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= '0;
            if_pc_q    <= 32'h0;
            if_ir_q    <= NOP;
            if_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            if_pc_q    <= if_pc_d;
            if_ir_q    <= if_ir_d;
            if_valid_q <= if_valid_d;
            err_q      <= err_d;
        end
    end

    assign if_pc    = if_pc_q;
    assign if_ir    = if_ir_q;
    assign if_valid = if_valid_q;
    assign err      = err_q;
    assign running  = (state_q == ST_RUN);
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 128-word memory.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [31:0] load_data;
    logic        load_done;
    logic        halt_req;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        if_valid;
    logic        running;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    logic [31:0] mem [0:127];
    logic [31:0] prog [0:3];

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.DEPTH(128), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_we     (load_we),
        .load_data   (load_data),
        .load_done   (load_done),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .if_pc       (if_pc),
        .if_ir       (if_ir),
        .if_valid    (if_valid),
        .running     (running),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.we) begin
            mem[bus.addr[8:2]] <= bus.wdata;
            we_count <= we_count + 1;
        end
    end

    always_comb begin
        if (bus.addr[31:9] == 23'h0) bus.rdata = mem[bus.addr[8:2]];
        else                         bus.rdata = 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk("reset running", 32'(running), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset if_valid", 32'(if_valid), 32'd0);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset if_ir", if_ir, 32'h0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset imem_we", 32'(bus.we), 32'd0);
        chk("reset imem_addr", bus.addr, 32'h0);
    endtask

    task automatic test_load_and_fetch();
        we_count = 0;
        for (int i = 0; i < 4; i++) begin
            load_we   = 1'b1;
            load_data = prog[i];
            #1;
            chk("load imem_we", 32'(bus.we), 32'd1);
            chk("load imem_addr", bus.addr, 32'(i * 4));
            chk("load imem_wdata", bus.wdata, prog[i]);
            tick();
        end
        load_we = 1'b0;
        chk("load we count", 32'(we_count), 32'd4);
        for (int i = 0; i < 4; i++) chk("load mem word", mem[i], prog[i]);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("run after load_done", 32'(running), 32'd1);
        chk("no valid 1 edge after load_done", 32'(if_valid), 32'd0);
        tick();
        chk("first valid", 32'(if_valid), 32'd1);
        chk("first if_pc", if_pc, 32'h0);
        chk("first if_ir", if_ir, prog[0]);
        chk("imem_addr follows pc", bus.addr, 32'h4);
        chk("imem_we zero in RUN", 32'(bus.we), 32'd0);
        tick();
        chk("second if_pc", if_pc, 32'h4);
        chk("second if_ir", if_ir, prog[1]);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall if_pc", if_pc, 32'h4);
            chk("stall if_ir", if_ir, prog[1]);
            chk("stall if_valid", 32'(if_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("after stall if_pc", if_pc, 32'h8);
        chk("after stall if_ir", if_ir, prog[2]);
    endtask

    task automatic test_redirect(input logic with_stall);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        stall       = with_stall;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("bubble if_valid", 32'(if_valid), 32'd0);
        chk("bubble if_ir", if_ir, 32'h0);
        tick();
        chk("target if_valid", 32'(if_valid), 32'd1);
        chk("target if_pc", if_pc, 32'h0);
        chk("target if_ir", if_ir, prog[0]);
        if (!with_stall) begin
            tick();
            chk("post target if_pc", if_pc, 32'h4);
        end
    endtask

    task automatic test_misaligned();
        redirect    = 1'b1;
        redirect_pc = 32'h6;
        tick();
        redirect = 1'b0;
        chk("misaligned err", 32'(err), 32'd1);
        chk("misaligned halted", 32'(halted), 32'd1);
        chk("misaligned running", 32'(running), 32'd0);
        chk("misaligned if_valid", 32'(if_valid), 32'd0);
        load_we     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("halt imem_we", 32'(bus.we), 32'd0);
            tick();
        end
        load_we  = 1'b0;
        redirect = 1'b0;
        chk("halt still halted", 32'(halted), 32'd1);
        chk("halt if_valid", 32'(if_valid), 32'd0);
        chk("halt if_pc held", if_pc, 32'h0);
        chk("halt if_ir held", if_ir, prog[0]);
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        we_count = 0;
        for (int i = 0; i < 129; i++) begin
            load_we   = 1'b1;
            load_data = 32'h1000_0000 + 32'(i);
            #1;
            if (i == 128) chk("overflow write suppressed", 32'(bus.we), 32'd0);
            tick();
        end
        load_we = 1'b0;
        chk("overflow we count", 32'(we_count), 32'd128);
        chk("overflow err", 32'(err), 32'd1);
        chk("overflow last word", mem[127], 32'h1000_007F);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("overflow err sticky", 32'(err), 32'd1);
        n = 0;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        chk("edges to range halt", 32'(n), 32'd129);
        chk("range halt if_valid", 32'(if_valid), 32'd0);
        chk("range halt last if_pc", if_pc, 32'h1FC);
        chk("range halt last if_ir", if_ir, 32'h1000_007F);
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_we   = 1'b1;
        load_data = 32'hCAFE_0001;
        tick();
        load_we = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid-load reset ptr", bus.addr, 32'h0);
        for (int i = 0; i < 2; i++) begin
            load_we   = 1'b1;
            load_data = prog[i];
            tick();
        end
        load_we   = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        tick();
        chk("pre-reset if_pc", if_pc, 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid-run reset running", 32'(running), 32'd0);
        chk("mid-run reset halted", 32'(halted), 32'd0);
        chk("mid-run reset if_valid", 32'(if_valid), 32'd0);
        chk("mid-run reset if_pc", if_pc, 32'h0);
        chk("mid-run reset if_ir", if_ir, 32'h0);
        chk("mid-run reset err", 32'(err), 32'd0);
        chk("mid-run reset load_ptr", bus.addr, 32'h0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        chk("memory kept after reset", if_ir, prog[0]);
    endtask

    task automatic test_halt_req();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_req halted", 32'(halted), 32'd1);
        chk("halt_req if_valid", 32'(if_valid), 32'd0);
        chk("halt_req err clear", 32'(err), 32'd0);
    endtask

    initial begin
        prog[0] = 32'h0022_2820;
        prog[1] = 32'h2061_0006;
        prog[2] = 32'h0085_3022;
        prog[3] = 32'hAC64_0004;
        rst = 1'b0; load_we = 1'b0; load_data = '0; load_done = 1'b0;
        halt_req = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(negedge clk);
        test_reset();
        test_load_and_fetch();
        test_stall();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_misaligned();
        test_overflow();
        test_reset_mid();
        test_halt_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
